data_axi_bridge: RTL and testbench

Parametrised bridge from the RV core's data port (req/gnt/rvalid) to an AXI4 manager interface. It supports up to MAX_OUTSTANDING in-flight transactions, mixed reads and writes, and strictly in-order responses. Every granted request, reads and writes alike, gets exactly one rvalid_o pulse, with an error flag taken from RRESP/BRESP. It sits between the core data port and the NoC/AXI interconnect, replacing the single-transaction glue.

---
 rtl/ravenoc_pkg.sv | 53 +++++
 rtl/data_axi_ord_fifo.sv | 58 +++++
 rtl/data_axi_bridge.sv | 120 ++++++++++++
 tb/tb_data_axi_bridge.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ravenoc_pkg.sv
// Shared AXI4 types and encodings used by the NoC and its manager-side bridges.
// Responses carry the error indication in bit 1 (SLVERR/DECERR).
package ravenoc_pkg;
    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_DATA_WIDTH = 32;
    localparam int AXI_ID_WIDTH   = 4;

    localparam logic [1:0] FIXED = 2'b00;
    localparam logic [1:0] INCR  = 2'b01;
    localparam logic [1:0] WRAP  = 2'b10;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    localparam int AXI_RESP_ERR_BIT = 1;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]     awid;
        logic [AXI_ADDR_WIDTH-1:0]   awaddr;
        logic [7:0]                  awlen;
        logic [2:0]                  awsize;
        logic [1:0]                  awburst;
        logic                        awvalid;
        logic [AXI_DATA_WIDTH-1:0]   wdata;
        logic [AXI_DATA_WIDTH/8-1:0] wstrb;
        logic                        wlast;
        logic                        wvalid;
        logic                        bready;
        logic [AXI_ID_WIDTH-1:0]     arid;
        logic [AXI_ADDR_WIDTH-1:0]   araddr;
        logic [7:0]                  arlen;
        logic [2:0]                  arsize;
        logic [1:0]                  arburst;
        logic                        arvalid;
        logic                        rready;
    } s_axi_mosi_t;

    typedef struct packed {
        logic                        awready;
        logic                        wready;
        logic [AXI_ID_WIDTH-1:0]     bid;
        logic [1:0]                  bresp;
        logic                        bvalid;
        logic                        arready;
        logic [AXI_ID_WIDTH-1:0]     rid;
        logic [AXI_DATA_WIDTH-1:0]   rdata;
        logic [1:0]                  rresp;
        logic                        rlast;
        logic                        rvalid;
    } s_axi_miso_t;
endpackage

// File: rtl/data_axi_ord_fifo.sv
// Order FIFO remembering the type (0=read, 1=write) of each granted transaction.
// Pointers carry an extra lap bit so full and empty are told apart for any depth.
module data_axi_ord_fifo #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic arst,
    input  logic push,
    input  logic push_data,
    input  logic pop,
    output logic head,
    output logic full,
    output logic empty
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [IW:0] wr_ptr_reg;
    logic [IW:0] rd_ptr_reg;
    logic        mem_reg [DEPTH];

    // Wrap explicitly at DEPTH-1 so non-power-of-two depths work too.
    function automatic logic [IW:0] ptr_inc(input logic [IW:0] p);
        if (p[IW-1:0] == IW'(DEPTH - 1)) begin
            return {~p[IW], {IW{1'b0}}};
        end
        return p + (IW+1)'(1);
    endfunction

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[IW] != rd_ptr_reg[IW]) &&
                   (wr_ptr_reg[IW-1:0] == rd_ptr_reg[IW-1:0]);
    assign head  = mem_reg[rd_ptr_reg[IW-1:0]];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_mem
            always_ff @(posedge clk) begin
                if (push && !full && (wr_ptr_reg[IW-1:0] == IW'(gi))) begin
                    mem_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop && !empty) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
        end
    end
endmodule

// File: rtl/data_axi_bridge.sv
// Core data port (req/gnt/rvalid) to AXI4 manager bridge: single-beat bursts,
// up to MAX_OUTSTANDING in flight, responses returned strictly in request order.
module data_axi_bridge
    import ravenoc_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int AXI_ID          = 0
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic        write_en_i,
    input  logic [3:0]  byte_en_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output s_axi_mosi_t m_axi_mosi,
    input  s_axi_miso_t m_axi_miso
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [2:0] AXI_SIZE_WORD = 3'd2;

    logic [CW-1:0] count_reg, count_next;
    logic          aw_done_reg, aw_done_next;
    logic          w_done_reg, w_done_next;
    logic          full, can_issue, rd_issue, wr_issue;
    logic          aw_valid, w_valid, aw_hs, w_hs, rd_gnt, wr_gnt;
    logic          head_is_wr, fifo_empty, unused_fifo_full;
    logic          r_ready, b_ready, r_ret, b_ret, retire;
    logic          unused_miso;

    assign unused_miso = ^{m_axi_miso.bid, m_axi_miso.rid, m_axi_miso.rlast};

    // No full bypass: a retire in this cycle does not free a slot for this cycle.
    assign full      = (count_reg == CW'(MAX_OUTSTANDING));
    assign can_issue = req_i && !full && !arst;
    assign rd_issue  = can_issue && !write_en_i;
    assign wr_issue  = can_issue && write_en_i;

    assign aw_valid = wr_issue && !aw_done_reg;
    assign w_valid  = wr_issue && !w_done_reg;
    assign aw_hs    = aw_valid && m_axi_miso.awready;
    assign w_hs     = w_valid && m_axi_miso.wready;
    assign wr_gnt   = wr_issue && (aw_done_reg || aw_hs) && (w_done_reg || w_hs);
    assign rd_gnt   = rd_issue && m_axi_miso.arready;
    assign gnt_o    = rd_gnt || wr_gnt;

    assign aw_done_next = !gnt_o && (aw_done_reg || aw_hs);
    assign w_done_next  = !gnt_o && (w_done_reg || w_hs);

    // Only the channel matching the oldest transaction is accepted.
    assign r_ready  = !fifo_empty && !head_is_wr;
    assign b_ready  = !fifo_empty && head_is_wr;
    assign r_ret    = r_ready && m_axi_miso.rvalid;
    assign b_ret    = b_ready && m_axi_miso.bvalid;
    assign retire   = r_ret || b_ret;
    assign rvalid_o = retire;
    assign err_o    = (r_ret && m_axi_miso.rresp[AXI_RESP_ERR_BIT]) ||
                      (b_ret && m_axi_miso.bresp[AXI_RESP_ERR_BIT]);
    assign rdata_o  = r_ret ? m_axi_miso.rdata : '0;

    always_comb begin
        m_axi_mosi = '0;
        if (!arst) begin
            m_axi_mosi.awid    = AXI_ID_WIDTH'(AXI_ID);
            m_axi_mosi.awaddr  = addr_i;
            m_axi_mosi.awsize  = AXI_SIZE_WORD;
            m_axi_mosi.awburst = INCR;
            m_axi_mosi.awvalid = aw_valid;
            m_axi_mosi.wdata   = wdata_i;
            m_axi_mosi.wstrb   = byte_en_i;
            m_axi_mosi.wlast   = 1'b1;
            m_axi_mosi.wvalid  = w_valid;
            m_axi_mosi.bready  = b_ready;
            m_axi_mosi.arid    = AXI_ID_WIDTH'(AXI_ID);
            m_axi_mosi.araddr  = addr_i;
            m_axi_mosi.arsize  = AXI_SIZE_WORD;
            m_axi_mosi.arburst = INCR;
            m_axi_mosi.arvalid = rd_issue;
            m_axi_mosi.rready  = r_ready;
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({gnt_o, retire})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            count_reg   <= '0;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
        end else begin
            count_reg   <= count_next;
            aw_done_reg <= aw_done_next;
            w_done_reg  <= w_done_next;
        end
    end

    data_axi_ord_fifo #(
        .DEPTH(MAX_OUTSTANDING)
    ) u_ord_fifo (
        .clk       (clk),
        .arst      (arst),
        .push      (gnt_o),
        .push_data (write_en_i),
        .pop       (retire),
        .head      (head_is_wr),
        .full      (unused_fifo_full),
        .empty     (fifo_empty)
    );
endmodule

// File: tb/tb_data_axi_bridge.sv
// Directed bench for data_axi_bridge: a queue-based model checked every cycle
// plus literal expectations for each scenario.
module tb_data_axi_bridge;
    import ravenoc_pkg::*;

    localparam int MAXO = 2;

    logic        clk = 1'b0;
    logic        arst;
    logic        req_i;
    logic        gnt_o;
    logic        write_en_i;
    logic [3:0]  byte_en_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    s_axi_mosi_t m_axi_mosi;
    s_axi_miso_t m_axi_miso;

    int checks   = 0;
    int failures = 0;
    int txn_num  = 0;

    data_axi_bridge #(
        .MAX_OUTSTANDING(MAXO),
        .AXI_ID         (0)
    ) dut (
        .clk        (clk),
        .arst       (arst),
        .req_i      (req_i),
        .gnt_o      (gnt_o),
        .write_en_i (write_en_i),
        .byte_en_i  (byte_en_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .rvalid_o   (rvalid_o),
        .rdata_o    (rdata_o),
        .err_o      (err_o),
        .m_axi_mosi (m_axi_mosi),
        .m_axi_miso (m_axi_miso)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Model: outstanding transactions as a queue of types; responses accepted only for the head.
    bit q[$];
    bit aw_seen = 0;
    bit w_seen  = 0;

    always @(negedge clk) begin : model
        bit nonempty, hd_wr, full_m, e_ar, e_aw, e_w, e_gnt, e_rr, e_br, e_rret, e_bret, e_err;
        logic [31:0] e_rdata;
        if (arst) begin
            q.delete();
            aw_seen = 0;
            w_seen  = 0;
            chk("m_rst_mosi_zero", 32'(m_axi_mosi == '0), 1);
            chk("m_rst_gnt", 32'(gnt_o), 0);
            chk("m_rst_rvalid", 32'(rvalid_o), 0);
            chk("m_rst_rdata", rdata_o, 0);
            chk("m_rst_err", 32'(err_o), 0);
        end else begin
            nonempty = q.size() > 0;
            hd_wr    = nonempty ? q[0] : 1'b0;
            full_m   = q.size() >= MAXO;
            e_ar = req_i && !write_en_i && !full_m;
            e_aw = req_i && write_en_i && !full_m && !aw_seen;
            e_w  = req_i && write_en_i && !full_m && !w_seen;
            if (write_en_i)
                e_gnt = req_i && !full_m && (aw_seen || (e_aw && m_axi_miso.awready))
                                         && (w_seen || (e_w && m_axi_miso.wready));
            else
                e_gnt = e_ar && m_axi_miso.arready;
            e_rr    = nonempty && !hd_wr;
            e_br    = nonempty && hd_wr;
            e_rret  = e_rr && m_axi_miso.rvalid;
            e_bret  = e_br && m_axi_miso.bvalid;
            e_err   = e_rret ? m_axi_miso.rresp[1] : (e_bret ? m_axi_miso.bresp[1] : 1'b0);
            e_rdata = e_rret ? m_axi_miso.rdata : 32'h0;

            chk("m_gnt", 32'(gnt_o), 32'(e_gnt));
            chk("m_arvalid", 32'(m_axi_mosi.arvalid), 32'(e_ar));
            chk("m_awvalid", 32'(m_axi_mosi.awvalid), 32'(e_aw));
            chk("m_wvalid", 32'(m_axi_mosi.wvalid), 32'(e_w));
            chk("m_rready", 32'(m_axi_mosi.rready), 32'(e_rr));
            chk("m_bready", 32'(m_axi_mosi.bready), 32'(e_br));
            chk("m_rvalid_o", 32'(rvalid_o), 32'(e_rret || e_bret));
            chk("m_rdata_o", rdata_o, e_rdata);
            chk("m_err_o", 32'(err_o), 32'(e_err));
            if (e_ar) begin
                chk("m_araddr", m_axi_mosi.araddr, addr_i);
                chk("m_arlen", 32'(m_axi_mosi.arlen), 0);
                chk("m_arsize", 32'(m_axi_mosi.arsize), 2);
                chk("m_arburst", 32'(m_axi_mosi.arburst), 32'(INCR));
                chk("m_arid", 32'(m_axi_mosi.arid), 0);
            end
            if (e_aw) begin
                chk("m_awaddr", m_axi_mosi.awaddr, addr_i);
                chk("m_awlen", 32'(m_axi_mosi.awlen), 0);
                chk("m_awsize", 32'(m_axi_mosi.awsize), 2);
                chk("m_awburst", 32'(m_axi_mosi.awburst), 32'(INCR));
            end
            if (e_w) begin
                chk("m_wdata", m_axi_mosi.wdata, wdata_i);
                chk("m_wstrb", 32'(m_axi_mosi.wstrb), 32'(byte_en_i));
            end

            if (e_rret || e_bret) begin
                $display("txn %0d retired %s err=%0b rdata=0x%08h", txn_num,
                         hd_wr ? "WR" : "RD", err_o, rdata_o);
                txn_num++;
                void'(q.pop_front());
            end
            if (e_gnt) begin
                q.push_back(write_en_i);
                aw_seen = 0;
                w_seen  = 0;
            end else begin
                if (e_aw && m_axi_miso.awready) aw_seen = 1;
                if (e_w && m_axi_miso.wready) w_seen = 1;
            end
        end
    end

    // A pending request must keep req_i and write_en_i until granted.
    bit pend_prev = 0;
    bit we_prev   = 0;
    always @(negedge clk) begin
        if (arst) begin
            pend_prev <= 1'b0;
        end else begin
            if (pend_prev)
                assert (req_i && (write_en_i == we_prev))
                    else $error("protocol violation: request changed before grant");
            pend_prev <= req_i && !gnt_o;
            we_prev   <= write_en_i;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        req_i = 0; write_en_i = 0; byte_en_i = 0; addr_i = 0; wdata_i = 0;
        m_axi_miso = '0;
    endtask

    bit is_wr [10];

    initial begin
        arst = 1;
        idle_all();
        step();
        #2 chk("rst_mosi", 32'(m_axi_mosi == '0), 1);
        chk("rst_gnt", 32'(gnt_o), 0);
        chk("rst_rvalid", 32'(rvalid_o), 0);
        step();
        arst = 0;

        // Single read
        step(); req_i = 1; addr_i = 32'h1000; m_axi_miso.arready = 1;
        #2 chk("t1_gnt", 32'(gnt_o), 1);
        chk("t1_araddr", m_axi_mosi.araddr, 32'h1000);
        step(); idle_all(); m_axi_miso.rvalid = 1; m_axi_miso.rdata = 32'hDEADBEEF; m_axi_miso.rresp = OKAY;
        #2 chk("t1_rvalid", 32'(rvalid_o), 1);
        chk("t1_rdata", rdata_o, 32'hDEADBEEF);
        chk("t1_err", 32'(err_o), 0);
        step(); idle_all();
        #2 chk("t1_idle", 32'(rvalid_o), 0);

        // Write: AW accepted two cycles before W
        step(); req_i = 1; write_en_i = 1; addr_i = 32'h2000; wdata_i = 32'hA5A50F0F; byte_en_i = 4'b0110;
        m_axi_miso.awready = 1;
        #2 chk("t2_awv0", 32'(m_axi_mosi.awvalid), 1);
        chk("t2_wv0", 32'(m_axi_mosi.wvalid), 1);
        chk("t2_gnt0", 32'(gnt_o), 0);
        step();
        #2 chk("t2_awv1", 32'(m_axi_mosi.awvalid), 0);
        chk("t2_wv1", 32'(m_axi_mosi.wvalid), 1);
        chk("t2_gnt1", 32'(gnt_o), 0);
        step(); m_axi_miso.awready = 0; m_axi_miso.wready = 1;
        #2 chk("t2_gnt2", 32'(gnt_o), 1);
        chk("t2_wstrb", 32'(m_axi_mosi.wstrb), 32'h6);
        step(); idle_all(); m_axi_miso.bvalid = 1; m_axi_miso.bresp = SLVERR;
        #2 chk("t2_rvalid", 32'(rvalid_o), 1);
        chk("t2_err", 32'(err_o), 1);
        chk("t2_rdata", rdata_o, 0);
        step(); idle_all();

        // Three reads against MAX_OUTSTANDING=2 with responses withheld
        step(); req_i = 1; addr_i = 32'h3000; m_axi_miso.arready = 1;
        #2 chk("t3_gnt_a", 32'(gnt_o), 1);
        step(); addr_i = 32'h3004;
        #2 chk("t3_gnt_b", 32'(gnt_o), 1);
        step(); addr_i = 32'h3008;
        #2 chk("t3_full_gnt", 32'(gnt_o), 0);
        chk("t3_full_arvalid", 32'(m_axi_mosi.arvalid), 0);
        step();
        #2 chk("t3_full_gnt2", 32'(gnt_o), 0);
        step(); m_axi_miso.rvalid = 1; m_axi_miso.rdata = 32'h11111111;
        #2 chk("t3_ret_a", rdata_o, 32'h11111111);
        chk("t3_no_bypass", 32'(gnt_o), 0);
        step(); m_axi_miso.rdata = 32'h22222222;
        #2 chk("t3_ret_b", rdata_o, 32'h22222222);
        chk("t3_gnt_c", 32'(gnt_o), 1);
        step(); req_i = 0; m_axi_miso.arready = 0; m_axi_miso.rdata = 32'h33333333;
        #2 chk("t3_ret_c", rdata_o, 32'h33333333);
        step(); idle_all();
        #2 chk("t3_idle", 32'(rvalid_o), 0);

        // Write then read; R arrives first and must wait behind B
        step(); req_i = 1; write_en_i = 1; addr_i = 32'h4000; wdata_i = 32'hBEEF0001; byte_en_i = 4'hF;
        m_axi_miso.awready = 1; m_axi_miso.wready = 1;
        #2 chk("t4_wgnt", 32'(gnt_o), 1);
        step(); write_en_i = 0; addr_i = 32'h4004; m_axi_miso.awready = 0; m_axi_miso.wready = 0;
        m_axi_miso.arready = 1;
        #2 chk("t4_rgnt", 32'(gnt_o), 1);
        step(); idle_all(); m_axi_miso.rvalid = 1; m_axi_miso.rdata = 32'h55555555;
        #2 chk("t4_rready_blocked", 32'(m_axi_mosi.rready), 0);
        chk("t4_no_rvalid", 32'(rvalid_o), 0);
        step(); m_axi_miso.bvalid = 1; m_axi_miso.bresp = OKAY;
        #2 chk("t4_wr_first", 32'(rvalid_o), 1);
        chk("t4_wr_rdata", rdata_o, 0);
        step(); m_axi_miso.bvalid = 0;
        #2 chk("t4_rd_second", rdata_o, 32'h55555555);
        step(); idle_all();

        // Ten mixed transactions: grant and retire every cycle at count 1
        for (int i = 0; i < 10; i++) is_wr[i] = (i % 3 == 1);
        for (int i = 0; i <= 10; i++) begin
            step(); idle_all();
            if (i < 10) begin
                req_i = 1; write_en_i = is_wr[i]; addr_i = 32'h5000 + 32'(4 * i);
                wdata_i = 32'h01010101 * 32'(i); byte_en_i = 4'hF;
                m_axi_miso.arready = 1; m_axi_miso.awready = 1; m_axi_miso.wready = 1;
            end
            if (i >= 1) begin
                if (is_wr[i-1]) begin
                    m_axi_miso.bvalid = 1; m_axi_miso.bresp = (i - 1 == 4) ? SLVERR : OKAY;
                end else begin
                    m_axi_miso.rvalid = 1; m_axi_miso.rdata = 32'hC0DE0000 + 32'(i - 1);
                    m_axi_miso.rresp = (i - 1 == 6) ? DECERR : OKAY;
                end
            end
            #2;
            if (i < 10) chk("t5_gnt", 32'(gnt_o), 1);
            if (i >= 1) begin
                chk("t5_rvalid", 32'(rvalid_o), 1);
                chk("t5_err", 32'(err_o), (i - 1 == 4 || i - 1 == 6) ? 1 : 0);
            end
        end
        step(); idle_all();

        // Reset with two reads outstanding, then a fresh read
        step(); req_i = 1; addr_i = 32'h6000; m_axi_miso.arready = 1;
        step(); addr_i = 32'h6004;
        #2 chk("t6_gnt_b", 32'(gnt_o), 1);
        step(); arst = 1; addr_i = 32'h6008; m_axi_miso.rvalid = 1; m_axi_miso.rdata = 32'h77;
        #2 chk("t6_rst_gnt", 32'(gnt_o), 0);
        chk("t6_rst_arvalid", 32'(m_axi_mosi.arvalid), 0);
        chk("t6_rst_rvalid", 32'(rvalid_o), 0);
        chk("t6_rst_rready", 32'(m_axi_mosi.rready), 0);
        step(); idle_all();
        step(); arst = 0;
        step(); req_i = 1; addr_i = 32'h6010; m_axi_miso.arready = 1;
        #2 chk("t6_fresh_gnt", 32'(gnt_o), 1);
        step(); idle_all(); m_axi_miso.rvalid = 1; m_axi_miso.rdata = 32'hCAFEF00D;
        #2 chk("t6_fresh_rvalid", 32'(rvalid_o), 1);
        chk("t6_fresh_rdata", rdata_o, 32'hCAFEF00D);
        step(); idle_all();
        #2 chk("t6_idle", 32'(rvalid_o), 0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
